// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch button path: FSM state encodings,
// default hold/repeat timing for the 100 MHz board clock, and a width helper.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESSED   = 2'd1;
    localparam logic [1:0] ST_LONG_HELD = 2'd2;

    localparam int DEF_LONG_CYCLES   = 100_000_000;
    localparam int DEF_REPEAT_CYCLES = 25_000_000;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Single-flop edge detector: rise/fall compare the current level with the
// level seen at the previous clock edge.
module edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;
    assign fall = ~din & prev_q;

endmodule

// File: rtl/button_event_fsm.sv
// Converts a clean button level into single-cycle press/release/click/
// long-press/repeat pulses plus a held level for the stopwatch controller.
module button_event_fsm
    import stopwatch_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic press,
    output logic release_p,
    output logic click,
    output logic long_press,
    output logic repeat_p,
    output logic held
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    // cnt starts at 1 on the press edge, so it equals the number of edges the
    // button has been seen high; long_press lands LONG_CYCLES edges after press.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic rise;
    logic fall;

    // prev resets high so a button held through reset never reports a press.
    edge_detect #(
        .RESET_VAL(1'b1)
    ) u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (btn_level),
        .rise (rise),
        .fall (fall)
    );

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_PRESSED;
                    cnt_d   = CNT_W'(1);
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                // prev is always 1 here, so fall is exactly btn_level==0;
                // checking it first makes release win over terminal count.
                if (fall) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == LONG_TC) begin
                    state_d = ST_LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LONG_HELD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_TC) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press      = press_q;
    assign release_p  = release_q;
    assign click      = click_q;
    assign long_press = long_q;
    assign repeat_p   = repeat_q;
    assign held       = held_q;

endmodule
